// File: rtl/host_cpu_oci_dct_pkg.sv
// Shared definitions for the OCI compressed-trace (DCT) frame interface,
// used by the packer, the trace generator and the frame consumer.
package host_cpu_oci_dct_pkg;

  localparam int ATOM_W      = 2;
  localparam int FRAME_ATOMS = 15;
  localparam int COUNT_W     = 4;
  localparam int FRAME_W     = ATOM_W * FRAME_ATOMS;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    ENDED = 2'd2
  } dct_state_t;

  // Atom encoding agreed between trace generator and consumer.
  typedef enum logic [ATOM_W-1:0] {
    ATOM_IDLE   = 2'd0,
    ATOM_EXEC   = 2'd1,
    ATOM_SKIP   = 2'd2,
    ATOM_EXCEPT = 2'd3
  } dct_atom_t;

endpackage

// File: rtl/host_cpu_oci_dct_packer_outreg.sv
// Single-entry valid/ready holding register for one packed trace frame.
// The frame is held stable until the consumer accepts it.
module host_cpu_oci_dct_outreg
  import host_cpu_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic [COUNT_W-1:0] load_count,
  input  logic               ready,
  output logic [FRAME_W-1:0] frame,
  output logic [COUNT_W-1:0] count,
  output logic               valid,
  output logic               free
);

  logic [FRAME_W-1:0] frame_p1;
  logic [COUNT_W-1:0] count_p1;
  logic               vld_p1;

  // A held frame leaving this cycle makes room for the next one.
  assign free = !vld_p1 || ready;

  // Stage p1: frame presented to the consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_p1 <= '0;
      count_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (load) begin
      frame_p1 <= load_frame;
      count_p1 <= load_count;
      vld_p1   <= 1'b1;
    end else if (ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign frame = frame_p1;
  assign count = count_p1;
  assign valid = vld_p1;

endmodule

// File: rtl/host_cpu_oci_dct_packer.sv
// Producer side of the OCI compressed-trace frame interface: packs 2-bit
// trace atoms LSB-first into 15-atom frames and drives the end-of-test flush.
module host_cpu_oci_dct_packer
  import host_cpu_oci_dct_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               atom_valid,
  input  logic [ATOM_W-1:0]  atom,
  input  logic               test_ending,
  output logic [FRAME_W-1:0] dct_buffer,
  output logic [COUNT_W-1:0] dct_count,
  output logic               dct_valid,
  input  logic               dct_ready,
  output logic               test_has_ended,
  output logic [DROP_W-1:0]  dropped_atoms
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dct_state_t         state_p0;
  dct_state_t         state_next;
  logic [FRAME_W-1:0] acc_p0;
  logic [FRAME_W-1:0] acc_next;
  logic [COUNT_W-1:0] acc_count_p0;
  logic [COUNT_W-1:0] acc_count_next;
  logic [DROP_W-1:0]  dropped_p0;

  logic accumulating;
  logic flushing;
  logic ended;
  logic free;
  logic full;
  logic transfer;
  logic accept;
  logic drop;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ACCUM;
    else       state_p0 <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_p0;
    case (state_p0)
      ACCUM:   if (test_ending) state_next = FLUSH;
      // Ended only once the accumulator is empty and no frame is left waiting.
      FLUSH:   if (acc_count_p0 == '0 && free) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = ACCUM;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accumulating = 1'b0;
    flushing     = 1'b0;
    ended        = 1'b0;
    case (state_p0)
      ACCUM:   accumulating = 1'b1;
      FLUSH:   flushing     = 1'b1;
      ENDED:   ended        = 1'b1;
      default: accumulating = 1'b1;
    endcase
  end

  assign full     = (acc_count_p0 == COUNT_W'(FRAME_ATOMS));
  assign transfer = free && ((accumulating && full) ||
                             (flushing && acc_count_p0 != '0));
  assign accept   = atom_valid && accumulating && (!full || transfer);
  assign drop     = atom_valid && accumulating && full && !free;

  // A transfer empties the accumulator first, so a same-cycle atom lands in slot 0.
  always_comb begin
    acc_next       = acc_p0;
    acc_count_next = acc_count_p0;
    if (transfer) begin
      acc_next       = '0;
      acc_count_next = '0;
    end
    if (accept) begin
      acc_next       = acc_next | (FRAME_W'(atom) << (ATOM_W * int'(acc_count_next)));
      acc_count_next = acc_count_next + 1'b1;
    end
  end

  // Stage p0: accumulator and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0       <= '0;
      acc_count_p0 <= '0;
      dropped_p0   <= '0;
    end else begin
      acc_p0       <= acc_next;
      acc_count_p0 <= acc_count_next;
      if (drop) dropped_p0 <= sat_inc(dropped_p0);
    end
  end

  host_cpu_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (transfer),
    .load_frame (acc_p0),
    .load_count (acc_count_p0),
    .ready      (dct_ready),
    .frame      (dct_buffer),
    .count      (dct_count),
    .valid      (dct_valid),
    .free       (free)
  );

  assign test_has_ended = ended;
  assign dropped_atoms  = dropped_p0;

endmodule
